clint_rd_arbiter: RTL
=====================

# clint_rd_arbiter

Two-master read arbiter in front of the core-local timer (CLINT) read port. It accepts read requests from master 0 (LSU) and master 1 (debug/trace reader), grants one at a time, and forwards the address to the single CLINT read channel. It routes the returned data back to the granted master and holds the grant until that master's response handshake completes. It sits between the core-side memory interconnect and the CLINT slave, so the CLINT itself stays single-ported.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- m0_arvalid_i  in  1  master 0 read request
- m0_arready_o  out  1  master 0 request accepted
- m0_araddr_i  in  AW  master 0 read address
- m0_rvalid_o  out  1  master 0 read data valid
- m0_rready_i  in  1  master 0 ready for data
- m0_rdata_o  out  DW  master 0 read data
- m1_arvalid_i, m1_arready_o, m1_araddr_i, m1_rvalid_o, m1_rready_i, m1_rdata_o: same as m0, for master 1
- s_arvalid_o  out  1  request to CLINT
- s_arready_i  in  1  CLINT accepts address
- s_araddr_o  out  AW  address to CLINT
- s_rvalid_i  in  1  CLINT data valid
- s_rready_o  out  1  ready for CLINT data
- s_rdata_i  in  DW  CLINT read data

## Operation
- FSM states: IDLE, AR, R. Reset state is IDLE.
- Registers:
  - gnt: 1 bit, granted master
  - last: 1 bit, last served master; reset value 1
  - addr_q: AW bits, latched address
- IDLE:
  - Arbitration is combinational over m0_arvalid_i and m1_arvalid_i.
  - Only the winner sees mX_arready_o=1; the loser sees 0.
  - On the winner's handshake: addr_q <= winner's araddr, gnt <= winner, go to AR.
  - With no request, stay in IDLE.
- AR:
  - s_arvalid_o=1, s_araddr_o=addr_q.
  - Both mX_arready_o=0.
  - On s_arready_i=1, go to R.
- R:
  - m[gnt]_rvalid_o = s_rvalid_i.
  - s_rready_o = m[gnt]_rready_i.
  - The other master sees rvalid_o=0.
  - On s_rvalid_i && m[gnt]_rready_i: last <= gnt, go to IDLE.
- s_araddr_o is driven from addr_q in all states. s_arvalid_o=0 outside AR. s_rready_o=0 outside R.
- m0_rdata_o and m1_rdata_o both carry s_rdata_i. Only rvalid_o qualifies the data.
- A master dropping arvalid after acceptance has no effect; the transaction completes from addr_q.
- Exactly one outstanding transaction. There is no buffering of read data.

## Timing
- Reset values: all *_arready_o=0, *_rvalid_o=0, s_arvalid_o=0, s_rready_o=0, s_araddr_o=0. rdata follows s_rdata_i.
  - In IDLE after reset, arready becomes 1 combinationally as soon as a request is present.
- Cycle sequence:
  - Accept handshake at cycle N.
  - s_arvalid_o=1 from N+1 until s_arready_i.
  - With a CLINT that is ready immediately, slave rvalid appears at N+2 and is passed through in the same cycle.
  - A master rready at N+2 returns the FSM to IDLE at N+3.
  - Minimum request-to-request spacing is 3 cycles.
- The R-to-master path is combinational; no added latency.
- Simultaneous requests in IDLE: the tie is resolved per Configuration. A single requester always wins, regardless of last.
- A new request arriving during AR or R waits with arready=0. It is considered in the first IDLE cycle.
- Reset asserted mid-transaction: the FSM goes to IDLE at once and any in-flight read is dropped. The CLINT must be reset by the same event, otherwise its pending response is orphaned.

## Configuration
- CLINT_ARB_RR_EN defined: round-robin tie-break. On simultaneous requests, grant !last. After reset the first tie goes to master 0.
- CLINT_ARB_RR_EN undefined: fixed priority; master 0 always wins ties. last is still updated but ignored.

## Test plan
- Single read, m0 at 0x0200_BFF8, CLINT data 0x0000_1234:
  - m0_arready_o=1 in cycle N.
  - s_arvalid_o=1 with s_araddr_o=0x0200_BFF8 at N+1.
  - m0_rvalid_o=1 with m0_rdata_o=0x0000_1234 at N+2.
  - m1_rvalid_o stays 0 throughout.
- Both masters request continuously for 4 transactions:
  - With RR_EN, the grant order is 0,1,0,1.
  - Without RR_EN, the grant order is 0,0,0,0.
- m1 request arriving during m0's R state (m0_rready_i held 0 for 5 cycles):
  - m1_arready_o stays 0 until m0's response handshake.
  - m1 is then accepted in the next cycle.
- m0 drops arvalid and changes araddr to 0xDEAD_0000 one cycle after acceptance:
  - s_araddr_o stays at the originally latched address.
  - The transaction completes normally.
- Slave backpressure: s_arready_i=0 for 3 cycles, then 1.
  - s_arvalid_o stays high for 4 cycles.
  - Address is held stable throughout.
- reset driven low in R state with s_rvalid_i=1:
  - All valid and ready outputs go to 0 asynchronously, within the same cycle.
  - After release, the FSM is in IDLE and the next tie goes to master 0.

Source files
------------

// File: rtl/clint_rd_arbiter.sv
// Two-master read arbiter in front of the single-ported CLINT read channel.
// Build option: define CLINT_ARB_RR_EN for round-robin tie-break (default: master 0 wins ties).
module clint_rd_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          m0_arvalid_i,
  output logic          m0_arready_o,
  input  logic [AW-1:0] m0_araddr_i,
  output logic          m0_rvalid_o,
  input  logic          m0_rready_i,
  output logic [DW-1:0] m0_rdata_o,

  input  logic          m1_arvalid_i,
  output logic          m1_arready_o,
  input  logic [AW-1:0] m1_araddr_i,
  output logic          m1_rvalid_o,
  input  logic          m1_rready_i,
  output logic [DW-1:0] m1_rdata_o,

  output logic          s_arvalid_o,
  input  logic          s_arready_i,
  output logic [AW-1:0] s_araddr_o,
  input  logic          s_rvalid_i,
  output logic          s_rready_o,
  input  logic [DW-1:0] s_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q;
  logic          last_q;
  logic [AW-1:0] addr_q;

  logic          tie_m1;
  logic          win;
  logic          accept;
  logic          gnt_rready;
  logic          r_done;
  logic [AW-1:0] win_addr;

`ifdef CLINT_ARB_RR_EN
  assign tie_m1 = ~last_q;
`else
  // last is tracked in both builds; fixed priority never lets it steer a tie
  assign tie_m1 = last_q & 1'b0;
`endif

  always_comb begin
    win = 1'b0;
    if (m0_arvalid_i && m1_arvalid_i) begin
      win = tie_m1;
    end else if (m1_arvalid_i) begin
      win = 1'b1;
    end
  end

  // reset gates the accept so no master sees a handshake while reset is low
  assign accept     = reset && (state_q == IDLE) && (m0_arvalid_i || m1_arvalid_i);
  assign win_addr   = win ? m1_araddr_i : m0_araddr_i;
  assign gnt_rready = gnt_q ? m1_rready_i : m0_rready_i;
  assign r_done     = (state_q == R) && s_rvalid_i && gnt_rready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= win_addr;
        gnt_q  <= win;
      end
      if (r_done) begin
        last_q <= gnt_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    m0_rvalid_o  = 1'b0;
    m1_rvalid_o  = 1'b0;
    s_arvalid_o  = 1'b0;
    s_rready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        m0_arready_o = accept && !win;
        m1_arready_o = accept && win;
        if (accept) begin
          state_d = AR;
        end
      end
      AR: begin
        s_arvalid_o = 1'b1;
        if (s_arready_i) begin
          state_d = R;
        end
      end
      R: begin
        m0_rvalid_o = s_rvalid_i && !gnt_q;
        m1_rvalid_o = s_rvalid_i && gnt_q;
        s_rready_o  = gnt_rready;
        if (r_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_araddr_o = addr_q;
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;

endmodule
